// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frames receiver bytes (SYNC, LEN, payload) onto a payload write port.
// Defining UART_FRAME_CHECKSUM_EN adds a trailing mod-256 checksum byte and its CHK state.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  CLK100MHZ,
    input  logic                  RESETN,
    input  logic                  ENABLE,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_DONE,
    output logic                  RX_EN,
    output logic                  WR_EN,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  FRAME_VALID,
    output logic [7:0]            FRAME_LEN,
    input  logic                  FRAME_ACK,
    output logic                  FRAME_ERR,
    output logic [1:0]            ERR_CODE
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
`ifdef UART_FRAME_CHECKSUM_EN
        CHK,
`endif
        HOLD
    } state_t;

    state_t state, state_n;
    logic [TW-1:0] timer;
    logic [ADDR_WIDTH-1:0] idx;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
`endif
    logic in_frame, timeout, last, wr, err;
    logic [1:0] code;

    always_comb begin
        state_n = state;
        wr = 1'b0;
        err = 1'b0;
        code = ERR_CODE;
        in_frame = state == LEN || state == PAYLOAD
`ifdef UART_FRAME_CHECKSUM_EN
            || state == CHK
`endif
            ;
        timeout = in_frame && !RX_DONE && timer == TW'(TIMEOUT_CYCLES - 1);
        last = idx == ADDR_WIDTH'(FRAME_LEN - 8'd1);
        if (!ENABLE) begin
            state_n = IDLE;
        end else if (timeout) begin
            err = 1'b1;
            code = 2'b10;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = (RX_DONE && RX_DATA == SYNC_BYTE) ? LEN : IDLE;
                LEN: begin
                    if (RX_DONE && 8'(RX_DATA) == 8'd0) begin
                        err = 1'b1;
                        code = 2'b01;
                        state_n = IDLE;
                    end else if (RX_DONE) begin
                        state_n = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    wr = RX_DONE;
`ifdef UART_FRAME_CHECKSUM_EN
                    state_n = (RX_DONE && last) ? CHK : PAYLOAD;
`else
                    state_n = (RX_DONE && last) ? HOLD : PAYLOAD;
`endif
                end
`ifdef UART_FRAME_CHECKSUM_EN
                CHK: begin
                    if (RX_DONE && RX_DATA == sum) begin
                        state_n = HOLD;
                    end else if (RX_DONE) begin
                        err = 1'b1;
                        code = 2'b11;
                        state_n = IDLE;
                    end
                end
`endif
                HOLD: state_n = FRAME_ACK ? IDLE : HOLD;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!RESETN) begin
            state <= IDLE;
            RX_EN <= 1'b0;
            WR_EN <= 1'b0;
            WR_ADDR <= '0;
            WR_DATA <= '0;
            FRAME_VALID <= 1'b0;
            FRAME_LEN <= 8'd0;
            FRAME_ERR <= 1'b0;
            ERR_CODE <= 2'b00;
            timer <= '0;
            idx <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
            sum <= '0;
`endif
        end else begin
            state <= state_n;
            RX_EN <= ENABLE && state_n != HOLD;
            WR_EN <= wr;
            FRAME_VALID <= state_n == HOLD;
            FRAME_ERR <= err;
            ERR_CODE <= code;
            timer <= (in_frame && !RX_DONE) ? timer + TW'(1) : '0;
            if (state == LEN && state_n == PAYLOAD) begin
                FRAME_LEN <= 8'(RX_DATA);
                WR_ADDR <= '0;
                idx <= '0;
`ifdef UART_FRAME_CHECKSUM_EN
                sum <= '0;
`endif
            end
            // WR_ADDR shows the index of the byte being written this cycle
            if (wr) begin
                WR_ADDR <= idx;
                WR_DATA <= RX_DATA;
                idx <= idx + ADDR_WIDTH'(1);
`ifdef UART_FRAME_CHECKSUM_EN
                sum <= sum + RX_DATA;
`endif
            end
        end
    end
endmodule
